// File: rtl/frame_parser_watchdog_mon.sv
// frame_parser_watchdog_mon: per-channel stuck-state and hold-stretch watchdog with sticky flags,
// saturating event counts, first-error capture and a maskable registered interrupt.
module frame_parser_watchdog_mon #(
  parameter int NUM_CH = 2,
  parameter int STATE_W = 4,
  parameter logic [STATE_W-1:0] IDLE_CODE = 4'h0,
  parameter logic [STATE_W-1:0] VALIDATE_CODE = 4'h8,
  parameter int MAX_STATE_CYCLES = 4096,
  parameter int MAX_HOLD_CYCLES = 512,
  parameter int EVT_W = 8,
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [NUM_CH*STATE_W-1:0] ch_state,
  input  logic [NUM_CH-1:0]         ch_hold,
  input  logic                      clr,
  input  logic [1:0]                irq_mask,
  output logic [NUM_CH-1:0]         stuck_pulse,
  output logic [NUM_CH-1:0]         hold_pulse,
  output logic [NUM_CH-1:0]         stuck_sticky,
  output logic [NUM_CH-1:0]         hold_sticky,
  output logic [NUM_CH*EVT_W-1:0]   stuck_evt_cnt,
  output logic [NUM_CH*EVT_W-1:0]   hold_evt_cnt,
  output logic                      first_err_valid,
  output logic [CH_W-1:0]           first_err_ch,
  output logic                      first_err_type,
  output logic [STATE_W-1:0]        first_err_state,
  output logic                      irq
);
  localparam int SW = $clog2(MAX_STATE_CYCLES + 1);
  localparam int HW = $clog2(MAX_HOLD_CYCLES + 1);
  localparam logic [SW-1:0] S_MAX = SW'(MAX_STATE_CYCLES);
  localparam logic [SW-1:0] S_PRE = SW'(MAX_STATE_CYCLES - 1);
  localparam logic [HW-1:0] H_MAX = HW'(MAX_HOLD_CYCLES);
  localparam logic [HW-1:0] H_PRE = HW'(MAX_HOLD_CYCLES - 1);
  typedef enum logic {ARMED, TRIPPED} mon_e;
  logic [STATE_W-1:0] cur [NUM_CH];
  logic [STATE_W-1:0] state_q [NUM_CH];
  logic [SW-1:0] scnt_d [NUM_CH], scnt_q [NUM_CH];
  logic [HW-1:0] hcnt_d [NUM_CH], hcnt_q [NUM_CH];
  mon_e smon_d [NUM_CH], smon_q [NUM_CH], hmon_d [NUM_CH], hmon_q [NUM_CH];
  logic [EVT_W-1:0] stuck_evt_d [NUM_CH], stuck_evt_q [NUM_CH];
  logic [EVT_W-1:0] hold_evt_d [NUM_CH], hold_evt_q [NUM_CH];
  logic [NUM_CH-1:0] stuck_pulse_d, stuck_pulse_q, hold_pulse_d, hold_pulse_q;
  logic [NUM_CH-1:0] stuck_sticky_d, stuck_sticky_q, hold_sticky_d, hold_sticky_q;
  logic first_err_valid_d, first_err_valid_q, first_err_type_d, first_err_type_q, irq_d, irq_q;
  logic [CH_W-1:0] first_err_ch_d, first_err_ch_q;
  logic [STATE_W-1:0] first_err_state_d, first_err_state_q;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign cur[g] = ch_state[g*STATE_W +: STATE_W];
    assign stuck_evt_cnt[g*EVT_W +: EVT_W] = stuck_evt_q[g];
    assign hold_evt_cnt[g*EVT_W +: EVT_W] = hold_evt_q[g];
  end
  always_comb begin
    scnt_d = scnt_q;
    hcnt_d = hcnt_q;
    smon_d = smon_q;
    hmon_d = hmon_q;
    stuck_evt_d = stuck_evt_q;
    hold_evt_d = hold_evt_q;
    stuck_pulse_d = '0;
    hold_pulse_d = '0;
    stuck_sticky_d = stuck_pulse_q | (stuck_sticky_q & {NUM_CH{~clr}});
    hold_sticky_d = hold_pulse_q | (hold_sticky_q & {NUM_CH{~clr}});
    for (int c = 0; c < NUM_CH; c++) begin
      scnt_d[c] = (enable && cur[c] == state_q[c] && cur[c] != IDLE_CODE) ? scnt_q[c] + SW'(scnt_q[c] != S_MAX) : '0;
      hcnt_d[c] = (enable && ch_hold[c] && cur[c] == VALIDATE_CODE) ? hcnt_q[c] + HW'(hcnt_q[c] != H_MAX) : '0;
      stuck_pulse_d[c] = smon_q[c] == ARMED && scnt_q[c] == S_PRE && scnt_d[c] == S_MAX;
      hold_pulse_d[c] = hmon_q[c] == ARMED && hcnt_q[c] == H_PRE && hcnt_d[c] == H_MAX;
      smon_d[c] = (!enable || scnt_d[c] == '0) ? ARMED : stuck_pulse_d[c] ? TRIPPED : smon_q[c];
      hmon_d[c] = (!enable || hcnt_d[c] == '0) ? ARMED : hold_pulse_d[c] ? TRIPPED : hmon_q[c];
      stuck_evt_d[c] = clr ? EVT_W'(stuck_pulse_q[c]) : stuck_evt_q[c] + EVT_W'(stuck_pulse_q[c] && stuck_evt_q[c] != '1);
      hold_evt_d[c] = clr ? EVT_W'(hold_pulse_q[c]) : hold_evt_q[c] + EVT_W'(hold_pulse_q[c] && hold_evt_q[c] != '1);
    end
    first_err_valid_d = first_err_valid_q & ~clr;
    first_err_ch_d = clr ? '0 : first_err_ch_q;
    first_err_type_d = first_err_type_q & ~clr;
    first_err_state_d = clr ? '0 : first_err_state_q;
    // Walk from the highest channel down so the lowest channel, and stuck over hold, is written last.
    if (!first_err_valid_q || clr)
      for (int c = NUM_CH - 1; c >= 0; c--) begin
        if (hold_pulse_q[c]) begin
          first_err_valid_d = 1'b1;
          first_err_ch_d = CH_W'(c);
          first_err_type_d = 1'b1;
          first_err_state_d = state_q[c];
        end
        if (stuck_pulse_q[c]) begin
          first_err_valid_d = 1'b1;
          first_err_ch_d = CH_W'(c);
          first_err_type_d = 1'b0;
          first_err_state_d = state_q[c];
        end
      end
    irq_d = |(stuck_sticky_q & {NUM_CH{irq_mask[0]}}) | |(hold_sticky_q & {NUM_CH{irq_mask[1]}});
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= IDLE_CODE;
        scnt_q[c] <= '0;
        hcnt_q[c] <= '0;
        smon_q[c] <= ARMED;
        hmon_q[c] <= ARMED;
        stuck_evt_q[c] <= '0;
        hold_evt_q[c] <= '0;
      end
      stuck_pulse_q <= '0;
      hold_pulse_q <= '0;
      stuck_sticky_q <= '0;
      hold_sticky_q <= '0;
      first_err_valid_q <= 1'b0;
      first_err_ch_q <= '0;
      first_err_type_q <= 1'b0;
      first_err_state_q <= '0;
      irq_q <= 1'b0;
    end else begin
      state_q <= cur;
      scnt_q <= scnt_d;
      hcnt_q <= hcnt_d;
      smon_q <= smon_d;
      hmon_q <= hmon_d;
      stuck_evt_q <= stuck_evt_d;
      hold_evt_q <= hold_evt_d;
      stuck_pulse_q <= stuck_pulse_d;
      hold_pulse_q <= hold_pulse_d;
      stuck_sticky_q <= stuck_sticky_d;
      hold_sticky_q <= hold_sticky_d;
      first_err_valid_q <= first_err_valid_d;
      first_err_ch_q <= first_err_ch_d;
      first_err_type_q <= first_err_type_d;
      first_err_state_q <= first_err_state_d;
      irq_q <= irq_d;
    end
  end
  assign stuck_pulse = stuck_pulse_q;
  assign hold_pulse = hold_pulse_q;
  assign stuck_sticky = stuck_sticky_q;
  assign hold_sticky = hold_sticky_q;
  assign first_err_valid = first_err_valid_q;
  assign first_err_ch = first_err_ch_q;
  assign first_err_type = first_err_type_q;
  assign first_err_state = first_err_state_q;
  assign irq = irq_q;
endmodule

// File: tb/tb_frame_parser_watchdog_mon.sv
// tb_frame_parser_watchdog_mon: directed and random stimulus; a run-length reference model
// queues expected pulse events and a separate monitor compares DUT outputs every cycle.
module tb_frame_parser_watchdog_mon;
  localparam int NC = 2, SW = 4, MS = 8, MH = 4, EW = 8;
  logic clk = 0, rst_n = 0, enable = 0, clr = 0;
  logic [NC*SW-1:0] ch_state = '0;
  logic [NC-1:0] ch_hold = '0;
  logic [1:0] irq_mask = '0;
  logic [NC-1:0] stuck_pulse, hold_pulse, stuck_sticky, hold_sticky;
  logic [NC*EW-1:0] stuck_evt_cnt, hold_evt_cnt;
  logic first_err_valid, first_err_ch, first_err_type, irq;
  logic [SW-1:0] first_err_state;
  frame_parser_watchdog_mon #(
    .NUM_CH(NC), .STATE_W(SW), .IDLE_CODE(4'h0), .VALIDATE_CODE(4'h8),
    .MAX_STATE_CYCLES(MS), .MAX_HOLD_CYCLES(MH), .EVT_W(EW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ch_state(ch_state), .ch_hold(ch_hold),
    .clr(clr), .irq_mask(irq_mask), .stuck_pulse(stuck_pulse), .hold_pulse(hold_pulse),
    .stuck_sticky(stuck_sticky), .hold_sticky(hold_sticky), .stuck_evt_cnt(stuck_evt_cnt),
    .hold_evt_cnt(hold_evt_cnt), .first_err_valid(first_err_valid), .first_err_ch(first_err_ch),
    .first_err_type(first_err_type), .first_err_state(first_err_state), .irq(irq)
  );
  always #5 clk = ~clk;
  typedef struct {int cyc; int ch; int t;} evt_t;
  evt_t exp_q[$];
  evt_t e;
  int checks = 0, errors = 0, cyc = 0;
  int run_len [NC][2];
  int ecnt [NC][2];
  bit pend [NC][2], stk [NC][2], ostk [NC][2];
  logic [SW-1:0] prev [NC];
  logic [SW-1:0] trip_st [NC][2];
  logic [SW-1:0] m_cur;
  bit m_fv, m_ft, m_irq, hit;
  int m_fch;
  logic [SW-1:0] m_fst;
  logic [SW-1:0] vals [4] = '{4'h0, 4'h3, 4'h5, 4'h8};
  task automatic chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  // Reference model: a fault fires when the count of consecutive qualifying samples first reaches the limit.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      for (int c = 0; c < NC; c++) begin
        prev[c] = 4'h0;
        for (int t = 0; t < 2; t++) begin
          run_len[c][t] = 0; ecnt[c][t] = 0; pend[c][t] = 0; stk[c][t] = 0;
        end
      end
      m_fv = 0; m_ft = 0; m_fch = 0; m_fst = 0; m_irq = 0;
      exp_q.delete();
    end else begin
      ostk = stk;
      m_irq = 0;
      for (int c = 0; c < NC; c++)
        for (int t = 0; t < 2; t++) begin
          if (ostk[c][t] && irq_mask[t]) m_irq = 1;
          stk[c][t] = pend[c][t] | (stk[c][t] & !clr);
          ecnt[c][t] = clr ? int'(pend[c][t]) : (pend[c][t] && ecnt[c][t] < 255) ? ecnt[c][t] + 1 : ecnt[c][t];
        end
      if (!m_fv || clr) begin
        hit = 0;
        if (clr) m_fv = 0;
        for (int c = 0; c < NC; c++)
          for (int t = 0; t < 2; t++)
            if (!hit && pend[c][t]) begin
              hit = 1; m_fv = 1; m_fch = c; m_ft = t[0]; m_fst = trip_st[c][t];
            end
      end
      for (int c = 0; c < NC; c++) begin
        m_cur = ch_state[c*SW +: SW];
        run_len[c][0] = (enable && m_cur == prev[c] && m_cur != 4'h0) ? run_len[c][0] + 1 : 0;
        run_len[c][1] = (enable && ch_hold[c] && m_cur == 4'h8) ? run_len[c][1] + 1 : 0;
        pend[c][0] = run_len[c][0] == MS;
        pend[c][1] = run_len[c][1] == MH;
        for (int t = 0; t < 2; t++)
          if (pend[c][t]) begin
            trip_st[c][t] = m_cur;
            exp_q.push_back('{cyc: cyc, ch: c, t: t});
          end
        prev[c] = m_cur;
      end
    end
  end
  always @(posedge clk) begin
    #1;
    for (int c = 0; c < NC; c++)
      for (int t = 0; t < 2; t++)
        if (t == 1 ? hold_pulse[c] : stuck_pulse[c]) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pulse ch%0d type%0d: got pulse at cycle %0d, expected none", c, t, cyc);
          end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.ch != c || e.t != t) begin
              errors++;
              $display("FAIL pulse: got ch%0d type%0d cycle %0d, expected ch%0d type%0d cycle %0d", c, t, cyc, e.ch, e.t, e.cyc);
            end
          end
        end
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      checks++; errors++;
      $display("FAIL missing_pulse: got no pulse, expected ch%0d type%0d at cycle %0d", e.ch, e.t, e.cyc);
    end
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("stuck_sticky%0d", c), int'(stuck_sticky[c]), int'(stk[c][0]));
      chk($sformatf("hold_sticky%0d", c), int'(hold_sticky[c]), int'(stk[c][1]));
      chk($sformatf("stuck_evt_cnt%0d", c), int'(stuck_evt_cnt[c*EW +: EW]), ecnt[c][0]);
      chk($sformatf("hold_evt_cnt%0d", c), int'(hold_evt_cnt[c*EW +: EW]), ecnt[c][1]);
    end
    chk("irq", int'(irq), int'(m_irq));
    chk("first_err_valid", int'(first_err_valid), int'(m_fv));
    if (m_fv) begin
      chk("first_err_ch", int'(first_err_ch), m_fch);
      chk("first_err_type", int'(first_err_type), int'(m_ft));
      chk("first_err_state", int'(first_err_state), int'(m_fst));
    end
  end
  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic set_st(int c, logic [SW-1:0] v);
    ch_state[c*SW +: SW] = v;
  endtask
  initial begin
    tick(3);
    chk("rst_outputs", int'({stuck_pulse, hold_pulse, stuck_sticky, hold_sticky, first_err_valid, irq}), 0);
    chk("rst_counts", int'({stuck_evt_cnt, hold_evt_cnt}), 0);
    rst_n = 1; enable = 1; irq_mask = 2'b01;
    set_st(0, 4'h3);
    tick(20);
    chk("p2_cnt0", int'(stuck_evt_cnt[7:0]), 1);
    chk("p2_irq", int'(irq), 1);
    chk("p2_capture", int'({first_err_valid, first_err_ch, first_err_type, first_err_state}), 'b1_0_0_0011);
    set_st(0, 4'h0); set_st(1, 4'h8); ch_hold = 2'b10; irq_mask = 2'b00;
    tick(6);
    ch_hold = 2'b00; set_st(1, 4'h0);
    tick(3);
    chk("p3_hold_cnt1", int'(hold_evt_cnt[15:8]), 1);
    chk("p3_irq", int'(irq), 0);
    clr = 1; tick(1); clr = 0;
    set_st(0, 4'h5); set_st(1, 4'h5);
    tick(12);
    chk("p4_capture_ch", int'(first_err_ch), 0);
    chk("p4_both_cnt", int'({stuck_evt_cnt[15:8], stuck_evt_cnt[7:0]}), 'h0101);
    set_st(0, 4'h0); set_st(1, 4'h8); ch_hold = 2'b10;
    tick(6);
    ch_hold = 2'b00; set_st(1, 4'h0);
    tick(3);
    chk("p4_capture_kept", int'({first_err_valid, first_err_ch, first_err_type, first_err_state}), 'b1_0_0_0101);
    for (int i = 0; i < 100; i++) begin
      set_st(0, ((i / 7) % 2) ? 4'h4 : 4'h3); set_st(1, ((i / 7) % 2) ? 4'h3 : 4'h4);
      tick(1);
    end
    set_st(0, 4'h0); set_st(1, 4'h0);
    tick(100);
    set_st(0, 4'h6);
    tick(9);
    clr = 1; tick(1); clr = 0;
    chk("p6_clr_event", int'({stuck_sticky[0], stuck_evt_cnt[7:0]}), 'h101);
    chk("p6_capture", int'({first_err_valid, first_err_ch, first_err_type, first_err_state}), 'b1_0_0_0110);
    set_st(0, 4'h0); tick(2);
    set_st(0, 4'h3);
    tick(7);
    rst_n = 0; tick(1);
    chk("p7_reset", int'({stuck_sticky, stuck_evt_cnt, first_err_valid}), 0);
    rst_n = 1;
    tick(8);
    chk("p7_no_early_pulse", int'(stuck_pulse[0]), 0);
    tick(1);
    chk("p7_fresh_pulse", int'(stuck_pulse[0]), 1);
    for (int i = 0; i < 260; i++) begin
      set_st(0, 4'h0); tick(1);
      set_st(0, 4'h3); tick(10);
    end
    chk("p8_saturate", int'(stuck_evt_cnt[7:0]), 255);
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NC; c++) begin
        if ($urandom_range(5) == 0) set_st(c, vals[$urandom_range(3)]);
        if ($urandom_range(3) == 0) ch_hold[c] = $urandom_range(3) != 0;
      end
      enable = $urandom_range(49) != 0;
      clr = $urandom_range(59) == 0;
      if ($urandom_range(99) == 0) irq_mask = 2'($urandom_range(3));
      rst_n = $urandom_range(799) != 0;
      tick(1);
    end
    rst_n = 1; clr = 0; enable = 1; ch_hold = '0; set_st(0, 4'h0); set_st(1, 4'h0);
    tick(5);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/frame_parser_watchdog_mon.md
Name: frame_parser_watchdog_mon

Overview:
Synthesizable, multi-channel successor to the simulation-only parser diagnostics. It watches the state bus and valid-hold of up to NUM_CH frame-parser instances. It detects two faults per channel: a state stuck away from IDLE, and valid-hold stretched in VALIDATE. Faults are recorded as sticky flags, saturating event counts, a first-error capture record and a maskable interrupt, all readable by the register block.

Parameters:
NUM_CH, 2, number of monitored parser channels (1..8)
STATE_W, 4, width of each parser state code
IDLE_CODE, 4'h0, state code excluded from stuck detection
VALIDATE_CODE, 4'h8, state code in which hold stretch is measured
MAX_STATE_CYCLES, 4096, consecutive unchanged non-IDLE samples that trip stuck fault
MAX_HOLD_CYCLES, 512, consecutive hold-in-VALIDATE samples that trip hold fault
EVT_W, 8, width of each saturating event counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = monitoring active; 0 = run counters forced to 0, no events
ch_state  in  NUM_CH*STATE_W  parser state per channel, channel c at [c*STATE_W +: STATE_W]
ch_hold  in  NUM_CH  frame_valid_hold per channel
clr  in  1  single-cycle clear of sticky flags, event counts and capture record
irq_mask  in  2  bit0 enables stuck faults onto irq, bit1 enables hold faults onto irq
stuck_pulse  out  NUM_CH  one-cycle pulse per stuck event
hold_pulse  out  NUM_CH  one-cycle pulse per hold event
stuck_sticky  out  NUM_CH  sticky stuck flag
hold_sticky  out  NUM_CH  sticky hold flag
stuck_evt_cnt  out  NUM_CH*EVT_W  saturating stuck event count per channel
hold_evt_cnt  out  NUM_CH*EVT_W  saturating hold event count per channel
first_err_valid  out  1  capture record holds an event
first_err_ch  out  $clog2(NUM_CH) (min 1)  channel of first event
first_err_type  out  1  0 = stuck, 1 = hold
first_err_state  out  STATE_W  ch_state of that channel at trip
irq  out  1  registered interrupt

Behaviour:
- Reset: all outputs 0; internal state_q per channel = IDLE_CODE; run and hold counters = 0; all monitors ARMED.
- Per-channel registers: state_q <= ch_state every cycle.
- Stuck run counter: counter width $clog2(MAX+1), saturates at MAX_STATE_CYCLES.
  - Increments when enable && cur == state_q && cur != IDLE_CODE.
  - Otherwise clears to 0.
- Hold counter: counter width $clog2(MAX+1), saturates at MAX_HOLD_CYCLES.
  - Increments when enable && ch_hold && cur == VALIDATE_CODE.
  - Otherwise clears to 0.
- Per-fault monitor FSM, states ARMED and TRIPPED:
  - ARMED -> TRIPPED on the edge where the counter goes MAX-1 -> MAX. The matching *_pulse is high for exactly the next cycle.
  - TRIPPED -> ARMED when the counter returns to 0. This prevents repeated pulses during one stuck episode.
  - Deasserting enable returns the FSM to ARMED.
- Sticky flags: set on pulse, cleared by clr. If set and clr occur in the same cycle, set wins.
- Event counters: increment on pulse and saturate at 2^EVT_W-1. clr zeroes them; clr plus pulse in the same cycle gives 1.
- Capture record:
  - Loads on the first pulse while first_err_valid = 0.
  - Simultaneous events: lowest channel index wins; within a channel, stuck beats hold.
  - Later events do not overwrite the record. clr clears valid; if clr coincides with an event, that event is captured.
- irq: registered, = |(stuck_sticky & {NUM_CH{irq_mask[0]}}) | |(hold_sticky & {NUM_CH{irq_mask[1]}}). Lags the sticky flags by one cycle.
- rst_n low mid-episode: everything returns to reset values immediately; counting restarts from 0 after release.
- Channels are fully independent apart from capture arbitration and irq.

Test Plan:
Bench parameters: NUM_CH=2, MAX_STATE_CYCLES=8, MAX_HOLD_CYCLES=4, EVT_W=8.
- Channel 0 state goes to 4'h3 and is held 20 cycles, enable=1 -> exactly one stuck_pulse[0], in the cycle after the 9th sampled edge of 3. stuck_sticky[0]=1, stuck_evt_cnt[0]=1, capture = ch0/type0/state 3. With irq_mask=2'b01, irq=1 one cycle later.
- Channel 1 held in 4'h8 with ch_hold=1 for 6 cycles, then hold dropped -> one hold_pulse[1], hold_evt_cnt[1]=1. With irq_mask=2'b00, irq stays 0.
- Both channels trip stuck on the same edge -> capture = ch0; both counts = 1. A later ch1 hold event leaves the capture unchanged.
- State toggles 3->4->3 every 7 cycles for 100 cycles -> no pulses. State held at IDLE (0) for 100 cycles -> no pulses.
- clr asserted on the same cycle as a stuck_pulse on ch0 after a prior event (cnt=1) -> sticky=1, count=1, capture reloaded with the new event.
- Assert rst_n=0 when ch0 run count = 6, release, hold state 3 -> pulse only after 9 fresh samples. Force count to 255 with repeated episodes -> stays at 255.
